// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes and FSM state encodings for spi_ram
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/spi_ram_if.sv
// rtl/spi_ram_if.sv - parallel word link between the SPI slave and spi_ram
interface spi_ram_if;

  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  // SPI slave side: presents command words, serialises read data
  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid
  );

  // RAM side
  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid
  );

endinterface

// File: rtl/spi_ram_core.sv
// rtl/spi_ram_core.sv - MEM_DEPTH x 8 single-port array with registered read
module sp_ram_core #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_rd_mask,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] r_rdata;

  // Array write; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register holds its value between reads so the output stays stable;
  // a masked read loads zero instead of touching the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 8'h00;
    end else if (i_re) begin
      r_rdata <= i_rd_mask ? 8'h00 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command-decoding RAM behind an SPI slave with fixed tx burst
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_ram_if.slave bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(TX_HOLD) + 1;
  localparam logic [ADDR_SIZE:0] LP_DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic                 r_rx_valid_q;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  state_e               r_state;
  logic [CW-1:0]        r_tx_cnt;

  logic [1:0]           w_op;
  logic [ADDR_SIZE-1:0] w_data;
  logic                 w_event;
  logic                 w_wr_oob;
  logic                 w_rd_oob;
  logic                 w_we;
  logic                 w_re;
  logic [AW-1:0]        w_addr;
  logic [7:0]           w_rdata;
  state_e               w_state_nxt;
  logic [CW-1:0]        w_tx_cnt_nxt;
  logic                 w_tx_valid;

  assign w_op     = bus.din[9:8];
  assign w_data   = bus.din[ADDR_SIZE-1:0];
  assign w_event  = bus.rx_valid && !r_rx_valid_q;
  assign w_wr_oob = {1'b0, r_wr_addr} >= LP_DEPTH;
  assign w_rd_oob = {1'b0, r_rd_addr} >= LP_DEPTH;

  // Out-of-range writes are dropped; reads while a burst is in flight are
  // ignored so dout cannot change under the slave's shifter
  assign w_we   = w_event && (w_op == OP_WR_DATA) && !w_wr_oob;
  assign w_re   = w_event && (w_op == OP_RD_DATA) && (r_state == ST_IDLE);
  assign w_addr = w_we ? r_wr_addr[AW-1:0] : r_rd_addr[AW-1:0];

  // Previous rx_valid level, so a held word yields a single event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_q <= 1'b0;
    end else begin
      r_rx_valid_q <= bus.rx_valid;
    end
  end

  // Address registers load on their own opcodes, in any FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else if (w_event) begin
      if (w_op == OP_WR_ADDR) begin
        r_wr_addr <= w_data;
      end
      if (w_op == OP_RD_ADDR) begin
        r_rd_addr <= w_data;
      end
    end
  end

  sp_ram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_re      (w_re),
    .i_rd_mask (w_rd_oob),
    .i_addr    (w_addr),
    .i_wdata   (w_data[7:0]),
    .o_rdata   (w_rdata)
  );

  // tx FSM state and burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tx_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx_cnt <= w_tx_cnt_nxt;
    end
  end

  // tx FSM next state; tx_valid decodes the state register so reset drops it at once
  always_comb begin
    w_state_nxt  = r_state;
    w_tx_cnt_nxt = r_tx_cnt;
    w_tx_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_re) begin
          w_state_nxt  = ST_SEND;
          w_tx_cnt_nxt = CW'(TX_HOLD - 1);
        end
      end
      ST_SEND: begin
        w_tx_valid = 1'b1;
        if (r_tx_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.dout     = w_rdata;
  assign bus.tx_valid = w_tx_valid;

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - directed self-checking bench for spi_ram
module tb_spi_ram;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  spi_ram_if bus ();

  spi_ram #(
    .MEM_DEPTH (128),
    .ADDR_SIZE (8),
    .TX_HOLD   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word: rx_valid high for one cycle, low for one cycle
  task automatic send(input logic [9:0] w);
    @(negedge clk);
    bus.din      = w;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // mode 0: plain burst, 1: RD_ADDR 0x10 + RD_DATA injected during burst,
  // 2: reset asserted mid-burst
  task automatic rd_burst(input string tag, input logic [7:0] exp, input int mode);
    int n;
    @(negedge clk);
    bus.din      = 10'h300;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check({tag, "_dout"}, {24'h0, bus.dout}, {24'h0, exp});
    n = 0;
    while (bus.tx_valid && n < 20) begin
      if (mode == 1) check({tag, "_stable"}, {24'h0, bus.dout}, {24'h0, exp});
      n++;
      if (mode == 1 && n == 2) begin
        bus.din      = 10'h210;
        bus.rx_valid = 1'b1;
      end else if (mode == 1 && n == 4) begin
        bus.din      = 10'h300;
        bus.rx_valid = 1'b1;
      end else begin
        bus.rx_valid = 1'b0;
      end
      if (mode == 2 && n == 3) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_txv"}, {31'h0, bus.tx_valid}, 32'h0);
        check({tag, "_rst_dout"}, {24'h0, bus.dout}, 32'h0);
        break;
      end
      @(negedge clk);
    end
    if (mode != 2) begin
      check({tag, "_len"}, n, 32'd8);
      check({tag, "_txv_end"}, {31'h0, bus.tx_valid}, 32'h0);
    end
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.din      = 10'h000;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txv", {31'h0, bus.tx_valid}, 32'h0);
    check("reset_dout", {24'h0, bus.dout}, 32'h0);
    rst_n = 1'b1;

    // write / readback
    send(10'h02A);
    send(10'h15C);
    send(10'h22A);
    rd_burst("wr_rd", 8'h5C, 0);

    // held rx_valid: din changing while held must not cause a second write
    send(10'h010);
    @(negedge clk);
    bus.din      = 10'h177;
    bus.rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.din = 10'h133;
    repeat (10) @(negedge clk);
    bus.rx_valid = 1'b0;
    send(10'h210);
    rd_burst("held", 8'h77, 0);

    // overlapping RD_DATA ignored, RD_ADDR during SEND still applied
    send(10'h22A);
    rd_burst("ovl", 8'h5C, 1);
    rd_burst("ovl_after", 8'h77, 0);

    // reset mid-burst, memory preserved, wr_addr back to 0
    rd_burst("rstb", 8'h77, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_txv", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_rel_dout", {24'h0, bus.dout}, 32'h0);
    send(10'h13C);
    send(10'h200);
    rd_burst("wr_addr0", 8'h3C, 0);
    send(10'h22A);
    rd_burst("mem_kept", 8'h5C, 0);

    // out of range with MEM_DEPTH=128: 0x90 must not alias onto 0x10
    send(10'h090);
    send(10'h1FF);
    send(10'h210);
    rd_burst("oob_alias", 8'h77, 0);
    send(10'h290);
    rd_burst("oob_rd", 8'h00, 0);

    // back-to-back, rx_valid toggling every cycle
    send(10'h001);
    send(10'h1A5);
    send(10'h201);
    @(negedge clk);
    bus.din      = 10'h300;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("b2b_dout", {24'h0, bus.dout}, 32'h0A5);
    check("b2b_txv", {31'h0, bus.tx_valid}, 32'h1);
    repeat (10) @(negedge clk);
    check("b2b_txv_end", {31'h0, bus.tx_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
